// File: rtl/never8_exec_ctrl_if.sv
// rtl/never8_exec_ctrl_if.sv - Never8 controller bus: run, program memory, ALU and status signals.
interface never8_exec_ctrl_if #(
   parameter int ADDR_W = 8
);
   logic              run_i;
   logic [ADDR_W-1:0] imem_addr_o;
   logic [9:0]        imem_data_i;
   logic [2:0]        alu_opcode_o;
   logic [4:0]        alu_a_o;
   logic [7:0]        alu_b_o;
   logic [7:0]        alu_result_i;
   logic              alu_zflag_i;
   logic              alu_c_i;
   logic [7:0]        acc_o;
   logic              z_flag_o;
   logic              c_flag_o;
   logic              halted_o;
   logic [1:0]        state_o;

   modport master (
      input  run_i, imem_data_i, alu_result_i, alu_zflag_i, alu_c_i,
      output imem_addr_o, alu_opcode_o, alu_a_o, alu_b_o, acc_o,
             z_flag_o, c_flag_o, halted_o, state_o
   );

   modport slave (
      output run_i, imem_data_i, alu_result_i, alu_zflag_i, alu_c_i,
      input  imem_addr_o, alu_opcode_o, alu_a_o, alu_b_o, acc_o,
             z_flag_o, c_flag_o, halted_o, state_o
   );
endinterface

// File: rtl/never8_exec_ctrl.sv
// rtl/never8_exec_ctrl.sv - Never8 fetch/decode/execute controller around the alu8bit datapath.
module never8_exec_ctrl #(
   parameter int              ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   never8_exec_ctrl_if.master    bus
);

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_DECODE  = 2'd1,
      S_EXECUTE = 2'd2,
      S_HALTED  = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [9:0]        ir_q, ir_d;
   logic [7:0]        acc_q, acc_d;
   logic              z_q, z_d;
   logic              c_q, c_d;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] target;

   assign pc_inc = pc_q + ADDR_W'(1);
   assign target = ir_q[ADDR_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         acc_q   <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         acc_q   <= acc_d;
         z_q     <= z_d;
         c_q     <= c_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      acc_d   = acc_q;
      z_d     = z_q;
      c_d     = c_q;
      case (state_q)
         S_FETCH: begin
            if (bus.run_i) state_d = S_DECODE;
         end
         S_DECODE: begin
            ir_d    = bus.imem_data_i;
            state_d = S_EXECUTE;
         end
         S_EXECUTE: begin
            state_d = S_FETCH;
            case (ir_q[9:8])
               2'b00: begin
                  acc_d = bus.alu_result_i;
                  z_d   = bus.alu_zflag_i;
                  c_d   = bus.alu_c_i;
                  pc_d  = pc_inc;
               end
               2'b01: pc_d = target;
               // JZ tests the flag left by the previous ALU-class instruction
               2'b10: pc_d = z_q ? target : pc_inc;
               default: state_d = S_HALTED;
            endcase
         end
         default: state_d = S_HALTED;
      endcase
   end

   assign bus.imem_addr_o  = pc_q;
   assign bus.alu_opcode_o = ir_q[7:5];
   assign bus.alu_a_o      = ir_q[4:0];
   assign bus.alu_b_o      = acc_q;
   assign bus.acc_o        = acc_q;
   assign bus.z_flag_o     = z_q;
   assign bus.c_flag_o     = c_q;
   assign bus.halted_o     = (state_q == S_HALTED);
   assign bus.state_o      = state_q;

endmodule
